spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_arbiter
// Description : Two-requester (write/read) arbiter in front of an SPI master,
//               with timeout supervision and round-robin or fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_arbiter #(
    parameter int TIMEOUT_CYC = 4095,
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_w,
    input  logic [7:0]  addr_w,
    input  logic [23:0] data_w,
    output logic        gnt_w,
    output logic        done_w,
    input  logic        req_r,
    input  logic [7:0]  addr_r,
    output logic        gnt_r,
    output logic        done_r,
    output logic [23:0] rdata,
    output logic [7:0]  spi_addr,
    output logic [23:0] spi_wdata,
    output logic        spi_read_begin,
    output logic        spi_write_begin,
    input  logic        spi_done,
    input  logic [23:0] spi_rdata,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [15:0] c_cnt_last = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_sel_rd;      // 1 = current transaction is a read
    logic        r_last_rd;     // 1 = the last completed transaction was a read
    logic [15:0] r_cnt;
    logic [7:0]  r_spi_addr;
    logic [23:0] r_spi_wdata;
    logic [23:0] r_rdata;
    logic        r_timeout_err;

    logic        w_start;
    logic        w_pick_rd;
    logic        w_fin_ok;
    logic        w_fin_to;
    logic        w_cnt_inc;
    logic        w_cnt_hit;

    assign w_cnt_hit = (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state    = r_state;
        w_start         = 1'b0;
        w_pick_rd       = 1'b0;
        w_fin_ok        = 1'b0;
        w_fin_to        = 1'b0;
        w_cnt_inc       = 1'b0;
        gnt_w           = 1'b0;
        gnt_r           = 1'b0;
        spi_write_begin = 1'b0;
        spi_read_begin  = 1'b0;
        done_w          = 1'b0;
        done_r          = 1'b0;
        busy            = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (req_w && req_r) begin
                    // Fixed priority always favours the config (write) path
                    w_pick_rd = (ROUND_ROBIN != 0) ? ~r_last_rd : 1'b0;
                end else begin
                    w_pick_rd = req_r;
                end
                if (req_w || req_r) begin
                    w_start      = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                gnt_w           = ~r_sel_rd;
                gnt_r           = r_sel_rd;
                spi_write_begin = ~r_sel_rd;
                spi_read_begin  = r_sel_rd;
                w_next_state    = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion landing on the last allowed cycle wins over timeout
                if (spi_done) begin
                    w_fin_ok     = 1'b1;
                    w_next_state = ST_DONE;
                end else if (w_cnt_hit) begin
                    w_fin_to     = 1'b1;
                    w_next_state = ST_DONE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_DONE: begin
                done_w       = ~r_sel_rd;
                done_r       = r_sel_rd;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_rd      <= 1'b0;
            r_last_rd     <= 1'b1;
            r_cnt         <= 16'd0;
            r_spi_addr    <= 8'd0;
            r_spi_wdata   <= 24'd0;
            r_rdata       <= 24'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_sel_rd    <= w_pick_rd;
                r_spi_addr  <= w_pick_rd ? addr_r : addr_w;
                r_spi_wdata <= w_pick_rd ? 24'd0 : data_w;
            end

            if (r_state == ST_ISSUE) begin
                r_cnt <= 16'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_fin_ok && r_sel_rd) begin
                r_rdata <= spi_rdata;
            end

            if (w_fin_to) begin
                r_timeout_err <= 1'b1;
                if (r_sel_rd) begin
                    r_rdata <= 24'd0;
                end
            end

            if (r_state == ST_DONE) begin
                r_last_rd <= r_sel_rd;
            end
        end
    end

    assign spi_addr    = r_spi_addr;
    assign spi_wdata   = r_spi_wdata;
    assign rdata       = r_rdata;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
